led_scan_pwm: RTL and testbench



---
 rtl/led_scan_pkg.sv | 17 +
 rtl/led_scan_timer.sv | 31 +++
 rtl/led_scan_pwm.sv | 94 +++++++++
 tb/tb_led_scan_pwm.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_scan_pkg.sv
// Shared constants and types for the iceFUN 8x4 LED matrix scan driver.
package led_scan_pkg;

  localparam int NUM_COLS = 4;
  localparam int ROW_BITS = 8;

  localparam logic [ROW_BITS-1:0] LEDS_OFF = 8'hFF;
  localparam logic [NUM_COLS-1:0] COLS_OFF = 4'hF;

  typedef logic [1:0] col_idx_t;

  // Active-low one-hot column select for a given column index.
  function automatic logic [NUM_COLS-1:0] col_select(input col_idx_t idx);
    return ~(NUM_COLS'(1) << idx);
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Slot/column timebase for the LED scan: slot_cnt wraps every SCAN_DIV cycles,
// col_idx advances on each wrap, and load marks the first cycle of every frame.
module led_scan_timer
  import led_scan_pkg::*;
#(
  parameter int SCAN_DIV = 2000,
  parameter int CNT_W    = $clog2(SCAN_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] slot_cnt,
  output col_idx_t         col_idx,
  output logic             load
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      col_idx  <= '0;
    end else if (slot_cnt == CNT_W'(SCAN_DIV - 1)) begin
      slot_cnt <= '0;
      col_idx  <= col_idx + col_idx_t'(1);
    end else begin
      slot_cnt <= slot_cnt + CNT_W'(1);
    end
  end

  // Also true in the first cycle after reset, so a fresh frame always reloads.
  assign load = (slot_cnt == '0) && (col_idx == '0);

endmodule

// File: rtl/led_scan_pwm.sv
// Column-scanned, double-buffered driver for the iceFUN 8x4 LED matrix.
// Define LED_SCAN_PWM_EN to enable brightness PWM inside each slot's lit window.
module led_scan_pwm
  import led_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 2000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ROW_BITS-1:0] leds1,
  input  logic [ROW_BITS-1:0] leds2,
  input  logic [ROW_BITS-1:0] leds3,
  input  logic [ROW_BITS-1:0] leds4,
  input  logic [3:0]          brightness,
  output logic [ROW_BITS-1:0] leds,
  output logic [NUM_COLS-1:0] lcol,
  output logic                frame_start
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  if (SCAN_DIV < 2 || SCAN_DIV > 65535) begin : g_bad_scan_div
    $error("led_scan_pwm: SCAN_DIV must be in 2..65535");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_blank
    $error("led_scan_pwm: BLANK_CYCLES must be in 0..SCAN_DIV-1");
  end

  logic [CNT_W-1:0]    slot_cnt;
  col_idx_t            col_idx;
  logic                load;
  logic [ROW_BITS-1:0] shadow [NUM_COLS];
  logic                above_blank;
  logic                pwm_on;
  logic                lit;

  led_scan_timer #(
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .slot_cnt (slot_cnt),
    .col_idx  (col_idx),
    .load     (load)
  );

  assign above_blank = int'(slot_cnt) >= BLANK_CYCLES;

`ifdef LED_SCAN_PWM_EN
  // Wide enough for SCAN_DIV*16, so neither side of the compare can wrap.
  localparam int PW = $clog2(SCAN_DIV * 16 + 1);

  logic [PW-1:0] pwm_lhs;
  logic [PW-1:0] pwm_rhs;

  // pwm_lhs wraps below BLANK_CYCLES, but lit is already gated by above_blank.
  assign pwm_lhs = (PW'(slot_cnt) - PW'(BLANK_CYCLES)) << 4;
  assign pwm_rhs = PW'(SCAN_DIV - BLANK_CYCLES) * (PW'(brightness) + PW'(1));
  assign pwm_on  = pwm_lhs < pwm_rhs;
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign pwm_on = 1'b1;
`endif

  assign lit = above_blank && pwm_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds        <= LEDS_OFF;
      lcol        <= COLS_OFF;
      frame_start <= 1'b0;
      for (int i = 0; i < NUM_COLS; i++) shadow[i] <= '0;
    end else begin
      frame_start <= load;
      if (load) begin
        shadow[0] <= leds1;
        shadow[1] <= leds2;
        shadow[2] <= leds3;
        shadow[3] <= leds4;
      end
      if (lit) begin
        lcol <= col_select(col_idx);
        leds <= ~shadow[col_idx];
      end else begin
        lcol <= COLS_OFF;
        leds <= LEDS_OFF;
      end
    end
  end

endmodule

// File: tb/tb_led_scan_pwm.sv
// Self-checking bench for led_scan_pwm: cycle-accurate reference model driven
// by the absolute cycle count since reset release, plus directed scenarios.
module tb_led_scan_pwm;

  localparam int SCAN_DIV = 20;
  localparam int BLANK    = 4;
  localparam int FRAME    = SCAN_DIV * 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] leds1, leds2, leds3, leds4;
  logic [3:0] brightness;
  logic [7:0] leds;
  logic [3:0] lcol;
  logic       frame_start;

  always #5 clk = ~clk;

  led_scan_pwm #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .leds1       (leds1),
    .leds2       (leds2),
    .leds3       (leds3),
    .leds4       (leds4),
    .brightness  (brightness),
    .leds        (leds),
    .lcol        (lcol),
    .frame_start (frame_start)
  );

  int checks = 0;
  int errors = 0;

  // Model state: cycles since reset release and the frame's latched columns.
  int          n;
  logic [7:0]  shadow_m [4];
  logic [12:0] exp_q [$];

  bit          obs_lit;
  logic [7:0]  obs_lit_leds;
  int          lit_count;
  int          first_lit;
  int          fs_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_lit(input int cnt);
    int slot;
    slot = cnt % SCAN_DIV;
    if (slot < BLANK) return 1'b0;
`ifdef LED_SCAN_PWM_EN
    return ((slot - BLANK) * 16) < ((SCAN_DIV - BLANK) * (int'(brightness) + 1));
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < 4; i++) shadow_m[i] = 8'h00;
  endtask

  // One clock: predict from current model state and inputs, advance, compare.
  task automatic step();
    int          col;
    bit          lit;
    logic [3:0]  e_col;
    logic [7:0]  e_leds;
    logic [12:0] e;
    col    = (n / SCAN_DIV) % 4;
    lit    = model_lit(n);
    e_col  = 4'hF;
    e_leds = 8'hFF;
    if (lit) begin
      e_col  = ~(4'b0001 << col);
      e_leds = ~shadow_m[col];
    end
    exp_q.push_back({((n % FRAME) == 0), e_col, e_leds});
    if ((n % FRAME) == 0) begin
      shadow_m[0] = leds1;
      shadow_m[1] = leds2;
      shadow_m[2] = leds3;
      shadow_m[3] = leds4;
    end
    n++;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("frame_start", {31'd0, frame_start}, {31'd0, e[12]});
    check("lcol", {28'd0, lcol}, {28'd0, e[11:8]});
    check("leds", {24'd0, leds}, {24'd0, e[7:0]});
    check("lcol_onehot", {31'd0, (lcol == 4'hF) || ($countones(~lcol) == 1)}, 32'd1);
    obs_lit = (lcol != 4'hF);
    if (obs_lit) obs_lit_leds = leds;
    if (frame_start) fs_count++;
  endtask

  task automatic align_slot();
    while ((n % SCAN_DIV) != 0) step();
  endtask

  task automatic run_slot();
    lit_count = 0;
    first_lit = -1;
    for (int k = 0; k < SCAN_DIV; k++) begin
      step();
      if (obs_lit) begin
        lit_count++;
        if (first_lit < 0) first_lit = k;
      end
    end
  endtask

  task automatic check_brightness(input logic [3:0] br);
    int exp_cnt;
    brightness = br;
    align_slot();
    run_slot();
`ifdef LED_SCAN_PWM_EN
    exp_cnt = int'(br) + 1;
`else
    exp_cnt = 16;
`endif
    check($sformatf("lit_count_br%0d", br), lit_count, exp_cnt);
    check($sformatf("first_lit_br%0d", br), first_lit, BLANK);
  endtask

  initial begin
    rst        = 1'b1;
    leds1      = 8'h01;
    leds2      = 8'h02;
    leds3      = 8'h04;
    leds4      = 8'h80;
    brightness = 4'd15;
    obs_lit    = 1'b0;
    obs_lit_leds = 8'hFF;
    fs_count   = 0;
    model_reset();

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_leds", {24'd0, leds}, 32'hFF);
      check("rst_lcol", {28'd0, lcol}, 32'hF);
      check("rst_fs", {31'd0, frame_start}, 32'd0);
    end
    rst = 1'b0;

    // Two full frames of the basic column pattern.
    fs_count = 0;
    for (int s = 0; s < 8; s++) begin
      run_slot();
      check($sformatf("scan_lit_count_s%0d", s), lit_count, 16);
      check($sformatf("scan_first_lit_s%0d", s), first_lit, BLANK);
      check($sformatf("scan_leds_s%0d", s), {24'd0, obs_lit_leds},
            {24'd0, ~(s % 4 == 0 ? 8'h01 : s % 4 == 1 ? 8'h02 : s % 4 == 2 ? 8'h04 : 8'h80)});
    end
    check("scan_fs_pulses", fs_count, 2);

    // Double buffering: a change after the frame load waits for the next frame.
    run_slot();
    leds2 = 8'h3C;
    run_slot();
    check("dbuf_old_col1", {24'd0, obs_lit_leds}, 32'hFD);
    run_slot();
    leds1 = 8'hFF;
    run_slot();
    run_slot();
    check("dbuf_new_col0", {24'd0, obs_lit_leds}, 32'h00);
    run_slot();
    check("dbuf_new_col1", {24'd0, obs_lit_leds}, 32'hC3);

    // All-zero column still selects its lcol bit with rows dark.
    leds3 = 8'h00;
    while ((n % FRAME) != 0) step();
    run_slot();
    run_slot();
    run_slot();
    check("zero_col_lit_count", lit_count, 16);
    check("zero_col_leds", {24'd0, obs_lit_leds}, 32'hFF);

    check_brightness(4'd0);
    check_brightness(4'd7);
    check_brightness(4'd15);
    check_brightness(4'd3);

    // Asynchronous reset in column 2, slot_cnt 10.
    brightness = 4'd15;
    while ((n % FRAME) != (2 * SCAN_DIV + 10)) step();
    check("pre_rst_lit", {31'd0, obs_lit}, 32'd1);
    leds1 = 8'hA5;
    leds2 = 8'h5A;
    leds3 = 8'h0F;
    leds4 = 8'hF0;
    rst = 1'b1;
    #1;
    check("async_rst_leds", {24'd0, leds}, 32'hFF);
    check("async_rst_lcol", {28'd0, lcol}, 32'hF);
    check("async_rst_fs", {31'd0, frame_start}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_lcol", {28'd0, lcol}, 32'hF);
    rst = 1'b0;
    model_reset();
    fs_count = 0;
    run_slot();
    check("post_rst_fs", fs_count, 1);
    check("post_rst_col0", {24'd0, obs_lit_leds}, 32'h5A);
    check("post_rst_lit_count", lit_count, 16);

    // Randomized inputs and brightness, checked cycle by cycle.
    for (int i = 0; i < 2400; i++) begin
      if ($urandom_range(15, 0) == 0) begin
        case ($urandom_range(3, 0))
          0: leds1 = 8'($urandom);
          1: leds2 = 8'($urandom);
          2: leds3 = 8'($urandom);
          default: leds4 = 8'($urandom);
        endcase
      end
      if ($urandom_range(31, 0) == 0) brightness = 4'($urandom_range(15, 0));
      step();
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
